iterative_array_multiplier: RTL
===============================

# iterative_array_multiplier

Parametrised, multi-cycle shift-and-add multiplier for DATA_WIDTH-bit operands with a runtime signed/unsigned mode. It has valid/ready handshakes on both the input and output sides. It replaces purely combinational array multipliers where area matters more than throughput, and sits between a producer and consumer stage that both use valid/ready flow control. One multiplication is in flight at a time.

## Interface
- DATA_WIDTH, 16, operand width W in bits; legal range 2..64; result width is 2W.
- Clock_In  in  1  clock; all state updates on the rising edge.
- Reset_n_In  in  1  reset, asynchronous assert, active-low.
- In_Valid_In  in  1  operands and mode are valid this cycle.
- In_Ready_Out  out  1  block can accept operands; high only in IDLE.
- Signed_Mode_In  in  1  1 = two's-complement operands, 0 = unsigned; sampled only at accept.
- Data_A_In  in  W  multiplicand.
- Data_B_In  in  W  multiplier.
- Out_Valid_Out  out  1  Multiplied_Result_Out holds a completed product.
- Out_Ready_In  in  1  consumer accepts the result.
- Multiplied_Result_Out  out  2W  product, registered.
- Busy_Out  out  1  high in CALC and FIX states.

## Operation
- States:
  - IDLE: In_Ready_Out=1.
  - CALC: W iterations.
  - FIX: sign correction and output register load.
  - DONE: Out_Valid_Out=1, wait for the consumer.
- Accept occurs on a rising edge with In_Valid_In=1 in IDLE. On accept:
  - Latch mode.
  - Latch magnitude of A and B as W-bit unsigned. In signed mode a negative operand is two's-complement negated; 2^(W-1) is representable unsigned.
  - Latch negate flag = mode & (A[W-1] ^ B[W-1]).
  - Clear the 2W-bit accumulator and the iteration counter. Go to CALC.
- CALC, each cycle:
  - If multiplier bit[0]=1, accumulator += multiplicand placed at bit position count.
  - Shift the multiplier right by 1; count += 1.
  - After the W-th iteration go to FIX.
- FIX:
  - Multiplied_Result_Out <= negate ? (~acc + 1) : acc, truncated to 2W bits.
  - Out_Valid_Out <= 1. Go to DONE.
- DONE:
  - Hold the result stable while Out_Valid_Out=1.
  - On Out_Ready_In=1: Out_Valid_Out <= 0, go to IDLE.
- Width rules: the unsigned product always fits 2W bits. The signed extreme (-2^(W-1))² = 2^(2W-2) also fits, so there is no overflow in either mode.
- Operand inputs are ignored outside the accept edge; changes to them mid-calculation have no effect.
- In_Valid_In in any state other than IDLE is not accepted; the producer must hold it.
- Multiplied_Result_Out keeps its last value after the output handshake until the next FIX.

## Timing
- Reset values (asserted at any time, including mid-CALC/DONE):
  - State IDLE, In_Ready_Out=1, Out_Valid_Out=0, Busy_Out=0.
  - Multiplied_Result_Out=0; accumulator, counter and flags cleared.
  - An in-flight operation is discarded with no output.
- Latency: accept at edge 0; CALC on edges 1..W; FIX at edge W+1. Out_Valid_Out rises after edge W+1, i.e. 17 cycles for W=16.
- Minimum initiation interval is W+3 cycles (accept, W CALC, FIX, one DONE cycle with Out_Ready_In=1, return to IDLE). In_Ready_Out is low during the DONE handshake cycle, so there is no same-cycle re-accept.
- In_Ready_Out and Busy_Out are decoded from registered state only. There is no combinational path from any input to any output.
- Backpressure: DONE is held for any number of cycles. The result and Out_Valid_Out stay unchanged until Out_Ready_In is high on a rising edge.

## Test plan
- Reset then idle: Reset_n_In low for 3 cycles, then high. Required: In_Ready_Out=1, Out_Valid_Out=0, Busy_Out=0, Multiplied_Result_Out=0x00000000.
- Unsigned max, W=16: A=0xFFFF, B=0xFFFF, mode 0, Out_Ready_In=1.
  - Required: result 0xFFFE0001.
  - Out_Valid_Out rises exactly 17 cycles after the accept edge.
  - In_Ready_Out returns high the cycle after the handshake.
- Mode check on identical operands, A=0xFFFF, B=0x0002:
  - mode 0 -> 0x0001FFFE.
  - mode 1 -> 0xFFFFFFFE.
  - Also signed 0x8000×0x8000 -> 0x40000000, and signed 0x8000×0x0001 -> 0xFFFF8000.
- Zero and identity: 0x0000×0x1234 -> 0x00000000; 0x0001×0xBEEF unsigned -> 0x0000BEEF.
- Backpressure and input isolation:
  - Hold Out_Ready_In=0 for 10 cycles in DONE while toggling Data_A_In, Data_B_In and In_Valid_In.
  - Required: result stable, In_Ready_Out=0, no new accept. Release Out_Ready_In -> single handshake.
- Reset mid-operation: assert Reset_n_In 5 cycles into CALC. Required: outputs return to reset values immediately, and no Out_Valid_Out pulse ever appears. Then 0x0003×0x0005 -> 0x0000000F normally.
- Random: 500 random operand/mode pairs with random Out_Ready_In stalls, compared against the reference product.

Source files
------------

// File: rtl/iterative_array_multiplier_if.sv
// Operand/result handshake bundle for iterative_array_multiplier.
//   slave  : the multiplier side (takes operands, drives result and status)
//   master : the producer/consumer side
// Signals:
//   In_Valid_In / In_Ready_Out         operand handshake
//   Signed_Mode_In                     1 = two's-complement operands
//   Data_A_In / Data_B_In              multiplicand / multiplier, DATA_WIDTH bits
//   Out_Valid_Out / Out_Ready_In       result handshake
//   Multiplied_Result_Out              2*DATA_WIDTH-bit product
//   Busy_Out                           calculation in progress
interface iterative_array_multiplier_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                        In_Valid_In;
    logic                        In_Ready_Out;
    logic                        Signed_Mode_In;
    logic [DATA_WIDTH-1:0]       Data_A_In;
    logic [DATA_WIDTH-1:0]       Data_B_In;
    logic                        Out_Valid_Out;
    logic                        Out_Ready_In;
    logic [2*DATA_WIDTH-1:0]     Multiplied_Result_Out;
    logic                        Busy_Out;

    modport slave (
        input  In_Valid_In,
        input  Signed_Mode_In,
        input  Data_A_In,
        input  Data_B_In,
        input  Out_Ready_In,
        output In_Ready_Out,
        output Out_Valid_Out,
        output Multiplied_Result_Out,
        output Busy_Out
    );

    modport master (
        output In_Valid_In,
        output Signed_Mode_In,
        output Data_A_In,
        output Data_B_In,
        output Out_Ready_In,
        input  In_Ready_Out,
        input  Out_Valid_Out,
        input  Multiplied_Result_Out,
        input  Busy_Out
    );
endinterface

// File: rtl/iterative_array_multiplier.sv
// Multi-cycle shift-and-add multiplier, one operation in flight.
// Operands are converted to magnitudes at accept, multiplied unsigned over
// DATA_WIDTH cycles, then sign-corrected into the registered result.
// Ports:
//   Clock_In    rising-edge clock
//   Reset_n_In  asynchronous active-low reset
//   bus         iterative_array_multiplier_if.slave (operand/result handshakes)
module iterative_array_multiplier #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                          Clock_In,
    input  logic                          Reset_n_In,
    iterative_array_multiplier_if.slave   bus
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned ACC_W = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic [W-1:0]       mcand_q,      mcand_d;
    logic [W-1:0]       mplier_q,     mplier_d;
    logic [ACC_W-1:0]   acc_q,        acc_d;
    logic [CNT_W-1:0]   count_q,      count_d;
    logic               negate_q,     negate_d;
    logic [ACC_W-1:0]   result_q,     result_d;
    logic               out_valid_q,  out_valid_d;
    logic               in_ready_q,   in_ready_d;
    logic               busy_q,       busy_d;

    // Operand magnitudes; in signed mode -2^(W-1) maps to 2^(W-1), still fits W bits unsigned
    logic               a_is_neg;
    logic               b_is_neg;
    logic [W-1:0]       a_mag;
    logic [W-1:0]       b_mag;

    assign a_is_neg = bus.Signed_Mode_In & bus.Data_A_In[W-1];
    assign b_is_neg = bus.Signed_Mode_In & bus.Data_B_In[W-1];
    assign a_mag    = a_is_neg ? W'(~bus.Data_A_In + W'(1)) : bus.Data_A_In;
    assign b_mag    = b_is_neg ? W'(~bus.Data_B_In + W'(1)) : bus.Data_B_In;

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;
        negate_d    = negate_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.In_Valid_In) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    negate_d = bus.Signed_Mode_In & (bus.Data_A_In[W-1] ^ bus.Data_B_In[W-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + (ACC_W'(mcand_q) << count_q);
                end
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d    = negate_q ? ACC_W'(~acc_q + ACC_W'(1)) : acc_q;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.Out_Ready_In) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the upcoming state
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d == S_CALC) || (state_d == S_FIX);
    end

    // State and datapath registers
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            negate_q    <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            negate_q    <= negate_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.In_Ready_Out          = in_ready_q;
    assign bus.Out_Valid_Out         = out_valid_q;
    assign bus.Multiplied_Result_Out = result_q;
    assign bus.Busy_Out              = busy_q;

endmodule
